ledpanel_row_loader: RTL and testbench

//  Upstream feeder for the LED panel driver's video memory. Parses a byte stream of row

---
 rtl/ledpanel_pkg.sv | 13 +
 rtl/rgb565_byte_pair.sv | 29 ++
 rtl/ledpanel_row_loader.sv | 105 ++++++++++
 tb/tb_ledpanel_row_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ledpanel_pkg.sv
// ledpanel_pkg: shared geometry defaults, RGB565 layout, pixel type and row-loader states
package ledpanel_pkg;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_HEIGHT = 32;
    localparam int RED_W = 5;
    localparam int GRN_W = 6;
    localparam int BLU_W = 5;
    localparam int RED_LSB = 0;
    localparam int GRN_LSB = RED_LSB + RED_W;
    localparam int BLU_LSB = GRN_LSB + GRN_W;
    typedef logic [RED_W+GRN_W+BLU_W-1:0] pixel_t;
    typedef enum logic [2:0] {IDLE, LO, HI, TAIL, DROP} loader_state_t;
endpackage

// File: rtl/rgb565_byte_pair.sv
// rgb565_byte_pair: joins a low and a high byte into one registered RGB565 pixel with a valid pulse
module rgb565_byte_pair
    import ledpanel_pkg::*;
(
    input  logic       display_clock,
    input  logic       reset,
    input  logic       lo_we,
    input  logic       hi_we,
    input  logic       clear,
    input  logic [7:0] data,
    output pixel_t     pixel,
    output logic       valid
);
    logic [7:0] lo;
    logic has_lo;
    always_ff @(posedge display_clock) begin
        if (reset) begin
            lo <= '0;
            has_lo <= 1'b0;
            pixel <= '0;
            valid <= 1'b0;
        end else begin
            valid <= hi_we & has_lo;
            if (hi_we & has_lo) pixel <= {data, lo};
            if (lo_we) lo <= data;
            has_lo <= clear ? 1'b0 : lo_we ? 1'b1 : hi_we ? 1'b0 : has_lo;
        end
    end
endmodule

// File: rtl/ledpanel_row_loader.sv
// ledpanel_row_loader: parses row packets into RGB565 panel writes on display_clock.
// Define LEDPANEL_ROW_LOADER_ERRCNT_EN to add the saturating err_count output.
module ledpanel_row_loader
    import ledpanel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_BITS = 16
) (
    input  logic                 display_clock,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    input  logic                 s_sop,
    input  logic                 s_eop,
    output logic                 ctrl_en,
    output logic [ADDR_BITS-1:0] ctrl_addr,
    output pixel_t               ctrl_wdat,
    output logic                 row_done,
    output logic                 frame_done
`ifdef LEDPANEL_ROW_LOADER_ERRCNT_EN
    ,
    output logic [15:0]          err_count
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    loader_state_t state, state_nx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic sop_in, row_ok, last_col, lo_we, hi_we, clear, done_nx;
    assign sop_in = s_valid & s_sop;
    assign row_ok = 32'(s_data) < HEIGHT;
    assign last_col = col == CW'(WIDTH - 1);
    assign clear = sop_in | (s_valid & s_eop);
    always_comb begin
        state_nx = state;
        lo_we = 1'b0;
        hi_we = 1'b0;
        done_nx = 1'b0;
        if (sop_in) begin
            state_nx = s_eop ? IDLE : row_ok ? LO : DROP;
        end else if (s_valid) begin
            case (state)
                LO: begin
                    lo_we = !s_eop;
                    state_nx = s_eop ? IDLE : HI;
                end
                HI: begin
                    hi_we = 1'b1;
                    done_nx = last_col & s_eop;
                    state_nx = s_eop ? IDLE : last_col ? TAIL : LO;
                end
                TAIL, DROP: state_nx = s_eop ? IDLE : state;
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge display_clock) begin
        if (reset) begin
            state <= IDLE;
            row <= '0;
            col <= '0;
            ctrl_addr <= '0;
            row_done <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            row_done <= done_nx;
            frame_done <= done_nx && row == RW'(HEIGHT - 1);
            if (sop_in) begin
                row <= s_data[RW-1:0];
                col <= '0;
            end else if (hi_we) begin
                ctrl_addr <= ADDR_BITS'({row, col});
                col <= col + 1'b1;
            end
        end
    end
    rgb565_byte_pair u_pair (
        .display_clock(display_clock),
        .reset(reset),
        .lo_we(lo_we),
        .hi_we(hi_we),
        .clear(clear),
        .data(s_data),
        .pixel(ctrl_wdat),
        .valid(ctrl_en)
    );
`ifdef LEDPANEL_ROW_LOADER_ERRCNT_EN
    // An abandoned packet and a bad new row index can land on the same byte, so up to +2.
    logic err_old, err_new;
    logic [16:0] err_sum;
    always_comb begin
        err_old = sop_in ? state inside {LO, HI, TAIL}
                : s_valid & s_eop & (state == LO || state == TAIL || (state == HI && !last_col));
        err_new = sop_in & !row_ok;
        err_sum = 17'(err_count) + 17'(err_old) + 17'(err_new);
    end
    always_ff @(posedge display_clock) begin
        if (reset) err_count <= '0;
        else err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_ledpanel_row_loader.sv
// tb_ledpanel_row_loader: directed packets with a write scoreboard for ledpanel_row_loader
module tb_ledpanel_row_loader;
    import ledpanel_pkg::*;
    logic display_clock = 1'b0;
    logic reset = 1'b1;
    logic s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
    logic [7:0] s_data = '0;
    logic ctrl_en, row_done, frame_done;
    logic [15:0] ctrl_addr;
    pixel_t ctrl_wdat;
    int tests = 0, fails = 0, rd_cnt = 0;
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic done;
        logic frame;
    } exp_t;
    exp_t sb[$];
    exp_t e;
`ifdef LEDPANEL_ROW_LOADER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    ledpanel_row_loader dut (
        .display_clock(display_clock),
        .reset(reset),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_sop(s_sop),
        .s_eop(s_eop),
        .ctrl_en(ctrl_en),
        .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat),
        .row_done(row_done),
        .frame_done(frame_done)
`ifdef LEDPANEL_ROW_LOADER_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 display_clock = ~display_clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_err(input int exp);
`ifdef LEDPANEL_ROW_LOADER_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(exp));
`endif
    endtask

    task automatic put(input logic [7:0] d, input logic sop, input logic eop);
        s_valid = 1'b1;
        s_data = d;
        s_sop = sop;
        s_eop = eop;
        @(negedge display_clock);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_sop = 1'b0;
        s_eop = 1'b0;
        repeat (n) @(negedge display_clock);
    endtask

    // Row byte, then nbytes payload bytes of pixels base+col; eop on the final byte if requested.
    task automatic send_pkt(input int row, input int nbytes, input logic [15:0] base,
                            input logic eop, input int gap);
        logic [15:0] p;
        logic last;
        put(8'(row), 1'b1, nbytes == 0 && eop);
        if (gap > 0) idle(gap);
        for (int i = 0; i < nbytes; i++) begin
            p = base + 16'(i / 2);
            last = eop && i == nbytes - 1;
            if (i % 2 == 0) begin
                put(p[7:0], 1'b0, last);
            end else begin
                if (row < 32 && i / 2 < 64)
                    sb.push_back('{16'((row << 6) | (i / 2)), p, last && i == 127,
                                   last && i == 127 && row == 31});
                put(p[15:8], 1'b0, last);
            end
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic drain();
        idle(4);
        chk("sb_empty", 32'(sb.size()), 0);
    endtask

    always @(negedge display_clock) begin
        if (!reset) begin
            if (row_done) rd_cnt++;
            if (ctrl_en) begin
                chk("write_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ctrl_addr", 32'(ctrl_addr), 32'(e.addr));
                    chk("ctrl_wdat", 32'(ctrl_wdat), 32'(e.data));
                    chk("row_done", 32'(row_done), 32'(e.done));
                    chk("frame_done", 32'(frame_done), 32'(e.frame));
                end
            end else begin
                chk("stray_done", 32'({row_done, frame_done}), 0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge display_clock);
        chk("rst_en", 32'(ctrl_en), 0);
        chk("rst_addr", 32'(ctrl_addr), 0);
        chk("rst_wdat", 32'(ctrl_wdat), 0);
        chk("rst_done", 32'({row_done, frame_done}), 0);
        chk_err(0);
        reset = 1'b0;
        // stray bytes in IDLE, eop on row byte, one-byte packet
        put(8'h55, 1'b0, 1'b0);
        put(8'h66, 1'b0, 1'b1);
        send_pkt(6, 0, 16'h0, 1'b1, 0);
        put(8'h77, 1'b0, 1'b1);
        drain();
        chk_err(0);
        send_pkt(5, 128, 16'h1234, 1'b1, 0);
        drain();
        chk("t1_row_done_cnt", 32'(rd_cnt), 1);
        chk_err(0);
        send_pkt(31, 128, 16'hBEEF, 1'b1, 0);
        drain();
        chk("t2_row_done_cnt", 32'(rd_cnt), 2);
        send_pkt(2, 9, 16'h0200, 1'b1, 0);
        drain();
        chk_err(1);
        send_pkt(40, 128, 16'h4000, 1'b1, 0);
        drain();
        chk_err(2);
        send_pkt(3, 20, 16'h0300, 1'b0, 0);
        send_pkt(4, 128, 16'h0400, 1'b1, 0);
        drain();
        chk("t5_row_done_cnt", 32'(rd_cnt), 3);
        chk_err(3);
        send_pkt(1, 130, 16'h0100, 1'b1, 0);
        drain();
        chk("long_row_done_cnt", 32'(rd_cnt), 3);
        chk_err(4);
        send_pkt(7, 11, 16'h0700, 1'b0, 1);
        chk("t6_pre_sb", 32'(sb.size()), 0);
        reset = 1'b1;
        put(8'hAB, 1'b0, 1'b0);
        chk("t6_en", 32'(ctrl_en), 0);
        chk("t6_addr", 32'(ctrl_addr), 0);
        chk("t6_wdat", 32'(ctrl_wdat), 0);
        chk("t6_done", 32'({row_done, frame_done}), 0);
        chk_err(0);
        reset = 1'b0;
        idle(2);
        send_pkt(9, 128, 16'h0900, 1'b1, 0);
        drain();
        chk("t6_row_done_cnt", 32'(rd_cnt), 4);
        chk_err(0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
